// File: rtl/f_pc_gen_if.sv
// Fetch-PC generator bus: control/redirect inputs from the hazard unit, D stage and CP0,
// and PC/status outputs back to the F stage.
interface f_pc_gen_if #(
  parameter int PC_W = 32
);
  logic            en;
  logic            br_valid;
  logic [PC_W-1:0] br_target;
  logic            exc_req;
  logic            eret_req;
  logic [PC_W-1:0] epc;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic            fetch_exc;
  logic            redir_pend;
  logic [31:0]     icount;

  modport master (
    output en, br_valid, br_target, exc_req, eret_req, epc,
    input  pc, pc_plus4, fetch_exc, redir_pend, icount
  );

  modport slave (
    input  en, br_valid, br_target, exc_req, eret_req, epc,
    output pc, pc_plus4, fetch_exc, redir_pend, icount
  );
endinterface

// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator: reset/exception/eret/stall/redirect/sequential next-PC selection,
// stalled-branch latching and AdEL flagging. Define F_PC_ICOUNT_EN to build the PC-change counter.
module f_pc_gen #(
  parameter int            PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(32'h0000_3000),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_4180),
  parameter logic [PC_W-1:0] IMEM_LO   = PC_W'(32'h0000_3000),
  parameter logic [PC_W-1:0] IMEM_HI   = PC_W'(32'h0000_6ffc)
) (
  input logic      clk,
  input logic      reset,
  f_pc_gen_if.slave bus
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_tgt;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] next_pc;

  assign seq_pc = pc_q + PC_W'(4);

  // NOTE: every path assigns next_pc via the leading default, so no latch is inferred.
  always_comb begin
    next_pc = seq_pc;
    if (bus.exc_req)         next_pc = EXC_VEC;
    else if (bus.eret_req)   next_pc = bus.epc;
    else if (!bus.en)        next_pc = pc_q;
    else if (bus.br_valid)   next_pc = bus.br_target;
    else if (state == PEND)  next_pc = pend_tgt;
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VEC;
      pend_tgt <= '0;
      state    <= IDLE;
    end else begin
      pc_q <= next_pc;
      if (bus.exc_req || bus.eret_req) begin
        state <= IDLE;
      end else if (!bus.en) begin
        // A stalled redirect is held; a newer one overwrites the older target.
        if (bus.br_valid) begin
          pend_tgt <= bus.br_target;
          state    <= PEND;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = seq_pc;
  assign bus.redir_pend = (state == PEND);
  assign bus.fetch_exc  = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

`ifdef F_PC_ICOUNT_EN
  logic [31:0] icount_q;

  always_ff @(posedge clk) begin
    if (reset)                 icount_q <= '0;
    else if (next_pc != pc_q)  icount_q <= icount_q + 32'd1;
  end

  assign bus.icount = icount_q;
`else
  assign bus.icount = 32'd0;
`endif

endmodule
